// File: rtl/program_sequencer.sv
// Step sequencer driving the downstream overflow timeout counter: walks a programmable
// table of {duration, action} entries, one counter run per step.
module program_sequencer #(
   parameter int unsigned STEPS        = 8,
   parameter int unsigned ADDR_BITS    = 3,
   parameter int unsigned COUNTER_BITS = 32,
   parameter int unsigned ACT_BITS     = 8
) (
   input  logic                    i_CLK,
   input  logic                    i_RST_N,
   input  logic                    i_WR_EN,
   input  logic [ADDR_BITS-1:0]    i_WR_ADDR,
   input  logic [COUNTER_BITS-1:0] i_WR_DUR,
   input  logic [ACT_BITS-1:0]     i_WR_ACT,
   input  logic [ADDR_BITS-1:0]    i_LAST,
   input  logic                    i_LOOP,
   input  logic                    i_START,
   input  logic                    i_ABORT,
   input  logic                    i_CNT_OVF,
   output logic [COUNTER_BITS-1:0] o_CNT_LIM,
   output logic                    o_CNT_RST,
   output logic [ADDR_BITS-1:0]    o_STEP,
   output logic [ACT_BITS-1:0]     o_ACT,
   output logic                    o_BUSY,
   output logic                    o_DONE
);

   localparam logic [ADDR_BITS:0]   NUM_STEPS = (ADDR_BITS + 1)'(STEPS);
   localparam logic [ADDR_BITS-1:0] LAST_MAX  = ADDR_BITS'(STEPS - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_BITS-1:0]    step_q, step_d;
   logic [ADDR_BITS-1:0]    last_q, last_d;
   logic                    loop_q, loop_d;
   logic [COUNTER_BITS-1:0] cnt_lim_q, cnt_lim_d;
   logic                    cnt_rst_q, cnt_rst_d;
   logic [ACT_BITS-1:0]     act_q, act_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    wr_ok;

   logic [COUNTER_BITS-1:0] dur_tbl_q [STEPS];
   logic [ACT_BITS-1:0]     act_tbl_q [STEPS];

   assign wr_ok = i_WR_EN && !busy_q && ({1'b0, i_WR_ADDR} < NUM_STEPS);

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         for (int i = 0; i < int'(STEPS); i++) begin
            dur_tbl_q[i] <= '0;
            act_tbl_q[i] <= '0;
         end
      end else if (wr_ok) begin
         dur_tbl_q[i_WR_ADDR] <= i_WR_DUR;
         act_tbl_q[i_WR_ADDR] <= i_WR_ACT;
      end
   end

   // Abort wins over every other transition and leaves the counter cleared for one cycle.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      last_d    = last_q;
      loop_d    = loop_q;
      cnt_rst_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_START && !i_ABORT) begin
               state_d = StLoad;
               step_d  = '0;
               last_d  = (i_LAST > LAST_MAX) ? LAST_MAX : i_LAST;
               loop_d  = i_LOOP;
            end
         end
         StLoad: begin
            if (i_ABORT) begin
               state_d   = StIdle;
               cnt_rst_d = 1'b1;
            end else begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (i_ABORT) begin
               state_d   = StIdle;
               cnt_rst_d = 1'b1;
            end else if (i_CNT_OVF) begin
               if (step_q < last_q) begin
                  step_d  = step_q + ADDR_BITS'(1);
                  state_d = StLoad;
               end else if (loop_q) begin
                  step_d  = '0;
                  state_d = StLoad;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (state_d == StLoad) cnt_rst_d = 1'b1;
   end

   // Outputs are computed from the next state so every port comes straight from a flop.
   always_comb begin
      cnt_lim_d = cnt_lim_q;
      act_d     = '0;
      if (state_d == StLoad) begin
         cnt_lim_d = dur_tbl_q[step_d];
         act_d     = act_tbl_q[step_d];
      end else if (state_d == StRun) begin
         act_d = act_q;
      end
      busy_d = (state_d == StLoad) || (state_d == StRun);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q   <= StIdle;
         step_q    <= '0;
         last_q    <= '0;
         loop_q    <= 1'b0;
         cnt_lim_q <= '0;
         cnt_rst_q <= 1'b1;
         act_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         last_q    <= last_d;
         loop_q    <= loop_d;
         cnt_lim_q <= cnt_lim_d;
         cnt_rst_q <= cnt_rst_d;
         act_q     <= act_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign o_CNT_LIM = cnt_lim_q;
   assign o_CNT_RST = cnt_rst_q;
   assign o_STEP    = step_q;
   assign o_ACT     = act_q;
   assign o_BUSY    = busy_q;
   assign o_DONE    = done_q;

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Step sequencer that drives the overflow timeout counter in the program-control path. It holds a small programmable table of steps, each with a duration and an action code. For each step it loads the duration into the downstream counter as its limit, clears the counter, and advances when the counter's overflow flag comes back. It presents the current step's action code to the datapath and reports completion.

## Interface
- STEPS, 8: number of table entries.
- ADDR_BITS, 3: step index width; 2^ADDR_BITS >= STEPS.
- COUNTER_BITS, 32: duration width; must equal the downstream counter width.
- ACT_BITS, 8: action code width.

- i_CLK  in  1  clock, rising edge.
- i_RST_N  in  1  asynchronous reset, active low.
- i_WR_EN  in  1  table write strobe.
- i_WR_ADDR  in  ADDR_BITS  table entry to write.
- i_WR_DUR  in  COUNTER_BITS  duration for that entry.
- i_WR_ACT  in  ACT_BITS  action code for that entry.
- i_LAST  in  ADDR_BITS  index of the final step; sampled on start.
- i_LOOP  in  1  1 = wrap to step 0 after the final step; sampled on start.
- i_START  in  1  start request, level-sampled.
- i_ABORT  in  1  abort request, level-sampled.
- i_CNT_OVF  in  1  overflow flag from the downstream counter.
- o_CNT_LIM  out  COUNTER_BITS  limit to the downstream counter.
- o_CNT_RST  out  1  clear to the downstream counter, active high.
- o_STEP  out  ADDR_BITS  current step index.
- o_ACT  out  ACT_BITS  current action code; 0 when not running.
- o_BUSY  out  1  high in LOAD and RUN.
- o_DONE  out  1  one-cycle completion pulse.

## Operation
- Table:
  - STEPS entries of {dur, act}, all cleared to 0 by reset.
  - A write with i_WR_EN=1 takes effect at the clock edge only when o_BUSY=0. Writes while busy are dropped.
  - i_WR_ADDR >= STEPS is ignored.
- States:
  - IDLE -> LOAD on i_START=1 (and i_ABORT=0). On that edge: step=0, latch last = min(i_LAST, STEPS-1), latch loop = i_LOOP.
  - LOAD: lasts exactly one cycle.
    - o_CNT_RST=1, o_CNT_LIM=dur[step], o_ACT=act[step].
    - Always -> RUN.
  - RUN: o_CNT_RST=0, o_CNT_LIM and o_ACT held.
    - i_CNT_OVF sampled 0: stay in RUN.
    - i_CNT_OVF sampled 1, step<last: step+1 -> LOAD.
    - i_CNT_OVF sampled 1, step==last, loop=1: step=0 -> LOAD.
    - i_CNT_OVF sampled 1, step==last, loop=0: -> DONE.
  - DONE: lasts one cycle. o_DONE=1, o_ACT=0, o_STEP holds last, then -> IDLE.
- i_CNT_OVF is ignored outside RUN. A stale overflow from the previous step can never cause a skip, because LOAD always separates steps.
- i_ABORT=1 in LOAD or RUN has priority over all other transitions:
  - Next state is IDLE with o_CNT_RST=1 for that one following cycle (IDLE-abort cycle), o_ACT=0, and no o_DONE pulse.
  - i_ABORT in IDLE or DONE has no effect.
  - i_START=1 together with i_ABORT=1 in IDLE does not start.
- i_START while busy is ignored. i_START held high in IDLE restarts on the next edge after DONE->IDLE.
- Table contents are read live. The action code and limit for a step are captured when LOAD is entered; writes cannot happen while busy.
- Duration 0 is legal; the step ends on the counter's first overflow.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Reset values: o_CNT_LIM=0, o_CNT_RST=1, o_STEP=0, o_ACT=0, o_BUSY=0, o_DONE=0, state=IDLE.
  - o_CNT_RST drops to 0 on the first clock edge after reset release.
- Start latency: i_START seen at edge e0, LOAD outputs visible after e0.
- Overflow reaction: i_CNT_OVF high at edge e drives the next state at e.
- Bench counter model: the counter is held clear while o_CNT_RST=1. It increments on each edge after that, and ovf rises on the edge where count becomes dur+1.
- With that model, each step occupies dur+3 cycles from LOAD entry to the next LOAD or DONE entry.

## Test plan
- Reset mid-run (i_RST_N low during RUN of step 2) -> all outputs take reset values immediately; table reads back all zero after restart (o_CNT_LIM=0 in LOAD).
- Write {dur=4, act=8'hA1}, {dur=0, act=8'hB2} to entries 0 and 1; i_LAST=1, i_LOOP=0; pulse start -> o_ACT=A1 for 7 cycles, then B2 for 3 cycles, then o_DONE=1 for exactly one cycle; o_BUSY high for 10 cycles.
- Same table with i_LOOP=1 -> step sequence 0,1,0,1,... continues with no DONE. Abort in RUN of step 1 -> IDLE next edge, o_CNT_RST=1 for one cycle, o_ACT=0, no o_DONE.
- Force i_CNT_OVF=1 continuously from the bench -> each step lasts exactly 2 cycles (LOAD+RUN), and step 0 is never skipped.
- Write to entry 0 while o_BUSY=1 -> the write is dropped; the next run still uses the old value. i_LAST=7 with STEPS=5 -> the run ends after step 4.
- i_START and i_ABORT both high in IDLE -> stays IDLE; o_BUSY stays 0.
